// File: rtl/ahbl_sram_excl_if.sv
// ahbl_sram_excl_if: AHB-Lite slave port carrying the exclusive-access sideband (hexcl/hmaster/hexokay).
interface ahbl_sram_excl_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   logic              ahbls_hready;
   logic              ahbls_hready_resp;
   logic              ahbls_hresp;
   logic [W_ADDR-1:0] ahbls_haddr;
   logic              ahbls_hwrite;
   logic [1:0]        ahbls_htrans;
   logic [2:0]        ahbls_hsize;
   logic [2:0]        ahbls_hburst;
   logic [3:0]        ahbls_hprot;
   logic              ahbls_hmastlock;
   logic [W_DATA-1:0] ahbls_hwdata;
   logic [W_DATA-1:0] ahbls_hrdata;
   logic              ahbls_hexcl;
   logic [7:0]        ahbls_hmaster;
   logic              ahbls_hexokay;
   modport master (
      output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hburst,
             ahbls_hprot, ahbls_hmastlock, ahbls_hwdata, ahbls_hexcl, ahbls_hmaster,
      input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata, ahbls_hexokay
   );
   modport slave (
      input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hburst,
             ahbls_hprot, ahbls_hmastlock, ahbls_hwdata, ahbls_hexcl, ahbls_hmaster,
      output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata, ahbls_hexokay
   );
endinterface

// File: rtl/ahbl_sram_excl.sv
// ahbl_sram_excl: zero-wait AHB-Lite SRAM slave with a per-master exclusive-access monitor.
// The monitor is built only when AHBL_SRAM_EXCL_MON_EN is defined; otherwise hexokay is tied low.
module ahbl_sram_excl #(
   parameter int W_ADDR    = 32,
   parameter int W_DATA    = 32,
   parameter int DEPTH     = 1024,
   parameter int N_MASTERS = 2
) (
   input logic               clk,
   input logic               rst,
   ahbl_sram_excl_if.slave   bus
);
   localparam int NB    = W_DATA / 8;
   localparam int W_OFF = $clog2(NB);
   localparam int W_IDX = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

   state_t            state_q, state_d;
   logic [W_ADDR-1:0] addr;
   logic              acc, err, we, okay;
   logic [NB-1:0]     lanes, mask_d, mask_q;
   logic [W_IDX-1:0]  idx_d, idx_q;
   logic              write_q;
   logic [W_DATA-1:0] mem [DEPTH];
   logic              unused;

   assign addr   = bus.ahbls_haddr;
   assign acc    = bus.ahbls_hready && bus.ahbls_htrans[1];
   assign lanes  = (bus.ahbls_hsize >= 3'(W_OFF)) ? '1 : NB'((1 << (1 << bus.ahbls_hsize)) - 1);
   assign mask_d = lanes << addr[W_OFF-1:0];
   assign idx_d  = addr[W_OFF +: W_IDX];
   assign err    = bus.ahbls_hsize > 3'(W_OFF)
                || |(addr[W_OFF-1:0] & W_OFF'((1 << bus.ahbls_hsize) - 1))
                || |(addr >> (W_OFF + W_IDX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb state_d = (state_q == ERR1) ? ERR2 : acc ? (err ? ERR1 : DATA) : IDLE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         mask_q  <= '0;
         write_q <= 1'b0;
      end else if (acc && state_q != ERR1) begin
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         write_q <= bus.ahbls_hwrite;
      end
   end

   always_comb begin
      bus.ahbls_hready_resp = state_q != ERR1;
      bus.ahbls_hresp       = state_q == ERR1 || state_q == ERR2;
      bus.ahbls_hrdata      = (state_q == DATA && !write_q) ? mem[idx_q] : '0;
      bus.ahbls_hexokay     = okay;
   end

   // Writes commit at the edge ending the data phase; an async reset forces IDLE, so no write.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++)
         if (we && mask_q[b]) mem[idx_q][8*b +: 8] <= bus.ahbls_hwdata[8*b +: 8];
   end

`ifdef AHBL_SRAM_EXCL_MON_EN
   logic                 excl_q, pass;
   logic [7:0]           mst_q;
   logic [N_MASTERS-1:0] res_v_q, own, hit;
   logic [W_IDX-1:0]     res_w_q [N_MASTERS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         excl_q <= 1'b0;
         mst_q  <= '0;
      end else if (acc && state_q != ERR1) begin
         excl_q <= bus.ahbls_hexcl;
         mst_q  <= bus.ahbls_hmaster;
      end
   end

   always_comb begin
      own = '0;
      hit = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         own[i] = mst_q == 8'(i);
         hit[i] = res_v_q[i] && res_w_q[i] == idx_q;
      end
   end

   assign pass = |(own & hit);
   assign we   = state_q == DATA && write_q && (!excl_q || pass);
   assign okay = state_q == DATA && excl_q && (write_q ? pass : |own);

   // Any committed write kills every reservation on its word; a failed exclusive write kills the issuer's.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_v_q <= '0;
         for (int i = 0; i < N_MASTERS; i++) res_w_q[i] <= '0;
      end else if (state_q == DATA) begin
         for (int i = 0; i < N_MASTERS; i++)
            if (excl_q && !write_q && own[i]) begin
               res_v_q[i] <= 1'b1;
               res_w_q[i] <= idx_q;
            end else if (write_q && ((we && res_w_q[i] == idx_q) || (excl_q && own[i]))) begin
               res_v_q[i] <= 1'b0;
            end
      end
   end

   assign unused = ^{bus.ahbls_hburst, bus.ahbls_hprot, bus.ahbls_hmastlock};
`else
   assign we     = state_q == DATA && write_q;
   assign okay   = 1'b0;
   assign unused = ^{bus.ahbls_hburst, bus.ahbls_hprot, bus.ahbls_hmastlock, bus.ahbls_hexcl, bus.ahbls_hmaster};
`endif
endmodule

// File: tb/tb_ahbl_sram_excl.sv
// tb_ahbl_sram_excl: directed checks of the SRAM slave; expectations follow AHBL_SRAM_EXCL_MON_EN.
module tb_ahbl_sram_excl;
`ifdef AHBL_SRAM_EXCL_MON_EN
   localparam bit MON = 1'b1;
`else
   localparam bit MON = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   ahbl_sram_excl_if #(.W_ADDR(32), .W_DATA(32)) bus ();
   assign bus.ahbls_hready = bus.ahbls_hready_resp;

   ahbl_sram_excl #(.W_ADDR(32), .W_DATA(32), .DEPTH(1024), .N_MASTERS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic addr_ph(input logic [31:0] a, input logic wr, input logic [2:0] sz, input logic ex, input logic [7:0] m);
      bus.ahbls_htrans  = 2'b10;
      bus.ahbls_haddr   = a;
      bus.ahbls_hwrite  = wr;
      bus.ahbls_hsize   = sz;
      bus.ahbls_hexcl   = ex;
      bus.ahbls_hmaster = m;
   endtask

   task automatic idle_ph();
      bus.ahbls_htrans = 2'b00;
      bus.ahbls_hwrite = 1'b0;
      bus.ahbls_hexcl  = 1'b0;
   endtask

   // One non-pipelined transfer; outputs are sampled mid data phase.
   task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz, input logic ex,
                       input logic [7:0] m, input logic [31:0] wd,
                       output logic [31:0] rd, output logic ok, output logic rdy, output logic rsp);
      addr_ph(a, wr, sz, ex, m);
      @(posedge clk); #1;
      idle_ph();
      bus.ahbls_hwdata = wd;
      @(negedge clk);
      rd  = bus.ahbls_hrdata;
      ok  = bus.ahbls_hexokay;
      rdy = bus.ahbls_hready_resp;
      rsp = bus.ahbls_hresp;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.ahbls_hready_resp !== 1'b1) begin n_fail++; $display("FAIL reset_hready: got %b want 1", bus.ahbls_hready_resp); end
      n_checks++; if (bus.ahbls_hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b want 0", bus.ahbls_hresp); end
      n_checks++; if (bus.ahbls_hexokay !== 1'b0) begin n_fail++; $display("FAIL reset_hexokay: got %b want 0", bus.ahbls_hexokay); end
      n_checks++; if (bus.ahbls_hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h want 0", bus.ahbls_hrdata); end
      rst = 1'b0;
   endtask

   task automatic test_word();
      logic [31:0] rd; logic ok, rdy, rsp;
      xfer(32'h10, 1, 3'd2, 0, 0, 32'h12345678, rd, ok, rdy, rsp);
      n_checks++; if ({rdy, rsp, rd} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL word_wr: rdy/rsp/rd got %b/%b/%h want 1/0/0", rdy, rsp, rd); end
      xfer(32'h10, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL word_rd: got %h want 12345678", rd); end
      n_checks++; if ({rdy, rsp, ok} !== 3'b100) begin n_fail++; $display("FAIL word_rd_resp: rdy/rsp/ok got %b%b%b want 100", rdy, rsp, ok); end
   endtask

   task automatic test_lanes();
      logic [31:0] rd; logic ok, rdy, rsp;
      xfer(32'h13, 1, 3'd0, 0, 0, 32'hABABABAB, rd, ok, rdy, rsp);
      xfer(32'h10, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== 32'hAB345678) begin n_fail++; $display("FAIL byte_wr: got %h want ab345678", rd); end
      xfer(32'h14, 1, 3'd2, 0, 0, 32'h11111111, rd, ok, rdy, rsp);
      xfer(32'h16, 1, 3'd1, 0, 0, 32'hBEEFBEEF, rd, ok, rdy, rsp);
      xfer(32'h14, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== 32'hBEEF1111) begin n_fail++; $display("FAIL half_wr: got %h want beef1111", rd); end
   endtask

   task automatic test_excl_pass();
      logic [31:0] rd; logic ok, rdy, rsp;
      xfer(32'h20, 1, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      xfer(32'h20, 0, 3'd2, 1, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (ok !== MON) begin n_fail++; $display("FAIL excl_rd_okay: got %b want %b", ok, MON); end
      xfer(32'h20, 1, 3'd2, 1, 0, 32'hCAFE, rd, ok, rdy, rsp);
      n_checks++; if ({ok, rsp} !== {MON, 1'b0}) begin n_fail++; $display("FAIL excl_wr_pass: okay/hresp got %b/%b want %b/0", ok, rsp, MON); end
      xfer(32'h20, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== 32'hCAFE) begin n_fail++; $display("FAIL excl_pass_data: got %h want cafe", rd); end
   endtask

   task automatic test_excl_intervene();
      logic [31:0] rd; logic ok, rdy, rsp;
      xfer(32'h20, 0, 3'd2, 1, 0, 32'h0, rd, ok, rdy, rsp);
      xfer(32'h20, 1, 3'd2, 0, 1, 32'h1, rd, ok, rdy, rsp);
      n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL plain_wr_okay: got %b want 0", ok); end
      xfer(32'h20, 1, 3'd2, 1, 0, 32'h2, rd, ok, rdy, rsp);
      n_checks++; if ({ok, rsp, rdy} !== 3'b001) begin n_fail++; $display("FAIL excl_wr_fail: okay/hresp/rdy got %b%b%b want 001", ok, rsp, rdy); end
      xfer(32'h20, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== (MON ? 32'h1 : 32'h2)) begin n_fail++; $display("FAIL excl_fail_data: got %h want %h", rd, MON ? 32'h1 : 32'h2); end
      xfer(32'h20, 0, 3'd2, 1, 5, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL untracked_rd_okay: got %b want 0", ok); end
      xfer(32'h20, 1, 3'd2, 1, 5, 32'h77, rd, ok, rdy, rsp);
      n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL untracked_wr_okay: got %b want 0", ok); end
      xfer(32'h20, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== (MON ? 32'h1 : 32'h77)) begin n_fail++; $display("FAIL untracked_data: got %h want %h", rd, MON ? 32'h1 : 32'h77); end
   endtask

   task automatic test_two_masters();
      logic [31:0] rd; logic ok, rdy, rsp;
      xfer(32'h40, 1, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      xfer(32'h40, 0, 3'd2, 1, 0, 32'h0, rd, ok, rdy, rsp);
      xfer(32'h40, 0, 3'd2, 1, 1, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (ok !== MON) begin n_fail++; $display("FAIL m1_excl_rd_okay: got %b want %b", ok, MON); end
      xfer(32'h40, 1, 3'd2, 1, 1, 32'h55, rd, ok, rdy, rsp);
      n_checks++; if (ok !== MON) begin n_fail++; $display("FAIL m1_excl_wr_okay: got %b want %b", ok, MON); end
      xfer(32'h40, 1, 3'd2, 1, 0, 32'h66, rd, ok, rdy, rsp);
      n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL m0_excl_wr_okay: got %b want 0", ok); end
      xfer(32'h40, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== (MON ? 32'h55 : 32'h66)) begin n_fail++; $display("FAIL two_masters_data: got %h want %h", rd, MON ? 32'h55 : 32'h66); end
   endtask

   task automatic test_no_reservation();
      logic [31:0] rd; logic ok, rdy, rsp;
      xfer(32'h50, 1, 3'd2, 0, 0, 32'h5050, rd, ok, rdy, rsp);
      xfer(32'h50, 1, 3'd2, 1, 0, 32'h1234, rd, ok, rdy, rsp);
      n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL noprior_okay: got %b want 0", ok); end
      xfer(32'h50, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== (MON ? 32'h5050 : 32'h1234)) begin n_fail++; $display("FAIL noprior_data: got %h want %h", rd, MON ? 32'h5050 : 32'h1234); end
      xfer(32'h60, 1, 3'd2, 0, 0, 32'h6060, rd, ok, rdy, rsp);
      xfer(32'h60, 0, 3'd2, 1, 0, 32'h0, rd, ok, rdy, rsp);
      xfer(32'h64, 1, 3'd2, 1, 0, 32'h6464, rd, ok, rdy, rsp);
      n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL other_word_okay: got %b want 0", ok); end
      xfer(32'h60, 1, 3'd2, 1, 0, 32'h6161, rd, ok, rdy, rsp);
      n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL killed_res_okay: got %b want 0", ok); end
      xfer(32'h60, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== (MON ? 32'h6060 : 32'h6161)) begin n_fail++; $display("FAIL killed_res_data: got %h want %h", rd, MON ? 32'h6060 : 32'h6161); end
   endtask

   task automatic test_error();
      logic [31:0] rd; logic ok, rdy, rsp;
      logic [31:0] ea [4] = '{32'h01, 32'h1000, 32'h00, 32'h02};
      logic [2:0]  es [4] = '{3'd1, 3'd2, 3'd3, 3'd2};
      logic        ew [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      xfer(32'h00, 1, 3'd2, 0, 0, 32'h0A0B0C0D, rd, ok, rdy, rsp);
      for (int i = 0; i < 4; i++) begin
         addr_ph(ea[i], ew[i], es[i], 1'b1, 8'd0);
         @(posedge clk); #1;
         idle_ph();
         bus.ahbls_hwdata = 32'hFFFFFFFF;
         @(negedge clk);
         n_checks++; if ({bus.ahbls_hready_resp, bus.ahbls_hresp} !== 2'b01) begin n_fail++; $display("FAIL err%0d_cyc1: rdy/rsp got %b%b want 01", i, bus.ahbls_hready_resp, bus.ahbls_hresp); end
         @(posedge clk); #1;
         @(negedge clk);
         n_checks++; if ({bus.ahbls_hready_resp, bus.ahbls_hresp, bus.ahbls_hexokay} !== 3'b110) begin n_fail++; $display("FAIL err%0d_cyc2: rdy/rsp/ok got %b%b%b want 110", i, bus.ahbls_hready_resp, bus.ahbls_hresp, bus.ahbls_hexokay); end
         @(posedge clk); #1;
      end
      addr_ph(32'h01, 1, 3'd1, 0, 0);
      @(posedge clk); #1;
      bus.ahbls_hwdata = 32'hFFFFFFFF;
      addr_ph(32'h00, 0, 3'd2, 0, 0);
      @(negedge clk);
      n_checks++; if ({bus.ahbls_hready_resp, bus.ahbls_hrdata} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL err_hold: rdy/rd got %b/%h want 0/0", bus.ahbls_hready_resp, bus.ahbls_hrdata); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      idle_ph();
      @(negedge clk);
      n_checks++; if ({bus.ahbls_hready_resp, bus.ahbls_hresp, bus.ahbls_hrdata} !== {2'b10, 32'h0A0B0C0D}) begin n_fail++; $display("FAIL err_pipelined_rd: rdy/rsp/rd got %b%b/%h want 10/0a0b0c0d", bus.ahbls_hready_resp, bus.ahbls_hresp, bus.ahbls_hrdata); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic ok, rdy, rsp;
      addr_ph(32'h74, 1, 3'd2, 0, 0);
      @(posedge clk); #1;
      bus.ahbls_hwdata = 32'h99;
      addr_ph(32'h74, 0, 3'd2, 0, 0);
      @(posedge clk); #1;
      idle_ph();
      @(negedge clk);
      n_checks++; if ({bus.ahbls_hready_resp, bus.ahbls_hrdata} !== {1'b1, 32'h99}) begin n_fail++; $display("FAIL raw_same_word: rdy/rd got %b/%h want 1/99", bus.ahbls_hready_resp, bus.ahbls_hrdata); end
      @(posedge clk); #1;
      addr_ph(32'h78, 1, 3'd2, 0, 0);
      @(posedge clk); #1;
      bus.ahbls_hwdata = 32'hA5;
      addr_ph(32'h10, 0, 3'd2, 0, 0);
      @(posedge clk); #1;
      idle_ph();
      @(negedge clk);
      n_checks++; if (bus.ahbls_hrdata !== 32'hAB345678) begin n_fail++; $display("FAIL b2b_rd: got %h want ab345678", bus.ahbls_hrdata); end
      @(posedge clk); #1;
      xfer(32'h78, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== 32'hA5) begin n_fail++; $display("FAIL b2b_wr: got %h want a5", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic ok, rdy, rsp;
      xfer(32'h80, 1, 3'd2, 0, 0, 32'h80808080, rd, ok, rdy, rsp);
      xfer(32'h80, 0, 3'd2, 1, 0, 32'h0, rd, ok, rdy, rsp);
      addr_ph(32'h80, 1, 3'd2, 0, 1);
      @(posedge clk); #1;
      idle_ph();
      bus.ahbls_hwdata = 32'hDEAD;
      rst = 1'b1;
      #1;
      n_checks++; if ({bus.ahbls_hready_resp, bus.ahbls_hresp} !== 2'b10) begin n_fail++; $display("FAIL mid_rst_resp: rdy/rsp got %b%b want 10", bus.ahbls_hready_resp, bus.ahbls_hresp); end
      @(posedge clk); #1;
      rst = 1'b0;
      xfer(32'h80, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== 32'h80808080) begin n_fail++; $display("FAIL mid_rst_abort: got %h want 80808080", rd); end
      xfer(32'h80, 1, 3'd2, 1, 0, 32'h11, rd, ok, rdy, rsp);
      n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL mid_rst_res_clr: got %b want 0", ok); end
      xfer(32'h10, 0, 3'd2, 0, 0, 32'h0, rd, ok, rdy, rsp);
      n_checks++; if (rd !== 32'hAB345678) begin n_fail++; $display("FAIL mem_kept: got %h want ab345678", rd); end
   endtask

   initial begin
      bus.ahbls_haddr     = '0;
      bus.ahbls_hwrite    = 1'b0;
      bus.ahbls_htrans    = 2'b00;
      bus.ahbls_hsize     = 3'd2;
      bus.ahbls_hburst    = 3'd0;
      bus.ahbls_hprot     = 4'd0;
      bus.ahbls_hmastlock = 1'b0;
      bus.ahbls_hwdata    = '0;
      bus.ahbls_hexcl     = 1'b0;
      bus.ahbls_hmaster   = 8'd0;
      test_reset();
      test_word();
      test_lanes();
      test_excl_pass();
      test_excl_intervene();
      test_two_masters();
      test_no_reservation();
      test_error();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ahbl_sram_excl.md
Name: ahbl_sram_excl

Overview:
- AHB-Lite SRAM slave with a built-in exclusive-access monitor.
- Sits on one crossbar slave port. It is the responder end of the hexcl/hmaster/hexokay signalling that masters drive through the splitters and arbiters.
- Tracks one word-granular reservation per master. Exclusive writes complete only while the issuing master's reservation is intact.
- Exclusive-write success or failure is reported on ahbls_hexokay.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width; 32 or 64 only.
- DEPTH, 1024, memory depth in W_DATA words; power of two.
- N_MASTERS, 2, number of reservation entries; hmaster IDs 0..N_MASTERS-1 are tracked.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ahbls_hready  in  1  bus HREADY (address phase qualifier)
- ahbls_hready_resp  out  1  slave ready
- ahbls_hresp  out  1  1 = ERROR
- ahbls_haddr  in  W_ADDR  address
- ahbls_hwrite  in  1  write
- ahbls_htrans  in  2  transfer type
- ahbls_hsize  in  3  transfer size
- ahbls_hburst  in  3  ignored
- ahbls_hprot  in  4  ignored
- ahbls_hmastlock  in  1  ignored
- ahbls_hwdata  in  W_DATA  write data
- ahbls_hrdata  out  W_DATA  read data
- ahbls_hexcl  in  1  exclusive transfer
- ahbls_hmaster  in  8  master ID
- ahbls_hexokay  out  1  exclusive okay, data phase

Behaviour:
- Reset state: hready_resp=1, hresp=0, hexokay=0, hrdata=0, all reservations invalid, no pending data phase. Memory contents are not reset.
- Address phase is accepted when ahbls_hready && htrans[1]. Registered on accept: word index, byte lane mask, write, excl, master, error flag.
- Byte lane mask:
  - derived from haddr low bits and hsize (0/1/2, plus 3 when W_DATA=64);
  - little-endian.
- Error flag is set for any of:
  - misaligned access;
  - hsize wider than W_DATA;
  - haddr >= DEPTH*(W_DATA/8).
- OKAY transfers are zero-wait:
  - data phase hready_resp=1, hresp=0;
  - read data comes from an asynchronous-read array indexed by the registered word index, with all lanes returned;
  - write updates the enabled lanes at the clock edge ending the data phase.
- There is no read-after-write hazard: a read's data phase always follows the preceding write's commit edge.
- Error transfers take two cycles:
  - cycle 1: hready_resp=0, hresp=1;
  - cycle 2: hready_resp=1, hresp=1;
  - no memory write, reservations untouched, hexokay=0.
  - If an address phase is presented while cycle 1 is pending (hready low), it is not accepted. The pipelined address after an error is handled normally.
- FSM states:
  - IDLE: no data phase.
  - DATA: OKAY data phase.
  - ERR1 and ERR2: the two error-response cycles.
  - Transitions: accept+ok -> DATA; accept+err -> ERR1; ERR1 -> ERR2; DATA/ERR2 -> DATA, ERR1 or IDLE depending on a new accept.
- hrdata=0 outside read data phases.
- Monitor actions, taken at the data-phase commit edge (m = hmaster, tracked only if m < N_MASTERS):
  - Exclusive read, m tracked: res[m] <= {valid, word}; hexokay=1. Any previous res[m] is replaced.
  - Exclusive read, m untracked: plain read, hexokay=0.
  - Exclusive write, pass (res[m] valid and res[m].word == word): memory written; hexokay=1; every entry holding that word is invalidated, res[m] included.
  - Exclusive write, fail: memory NOT written; hexokay=0; res[m] invalidated; hresp stays OKAY.
  - Non-exclusive write: memory written; every entry holding that word is invalidated; hexokay=0.
  - Non-exclusive read: no monitor effect; hexokay=0.
- hexokay is combinational from the registered data-phase state and the reservation table. It is valid only while hready_resp=1 in a DATA phase.
- Simultaneous case: a reservation set by an exclusive read in the same cycle as another master's write to the same word cannot arise, because only one data phase exists at a time.
- Reset mid-transfer aborts it: memory is not written and reservations are cleared.

Optional Feature:
- Macro AHBL_SRAM_EXCL_MON_EN.
- Defined: monitor as described.
- Undefined:
  - no reservation storage;
  - hexokay constant 0;
  - exclusive writes perform as normal writes;
  - hexcl and hmaster ignored.

Test Plan:
- Write word 0x12345678 at 0x10, then read 0x10 -> hrdata=0x12345678, zero wait states, hresp=0.
- Byte write 0xAB to 0x13 over 0x12345678 -> read 0x10 returns 0xAB345678.
- Master 0: excl read 0x20 then excl write 0xCAFE to 0x20 -> both hexokay=1; read returns 0xCAFE.
- Master 0 excl read 0x20, master 1 normal write 0x1 to 0x20, master 0 excl write 0x2 to 0x20 -> hexokay=0; read returns 0x1.
- Masters 0 and 1 both excl read 0x40; master 1 excl write passes -> master 0's excl write to 0x40 then fails (hexokay=0).
- Halfword write to 0x01 (misaligned) -> hready_resp 0 then 1 with hresp=1 both cycles, memory unchanged. With AHBL_SRAM_EXCL_MON_EN undefined, excl write without a prior read -> write lands, hexokay=0.
